regfile_wport_arb: RTL and testbench



---
 rtl/regfile_wport_arb.sv | 133 +++++++++++++
 tb/tb_regfile_wport_arb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wport_arb.sv
// regfile_wport_arb: shares the single register-file write port between the
// writeback stage (A) and the multi-cycle unit (B). The granted write is
// registered onto the write port, and the in-flight write is forwarded to the
// two read ports. A has priority over B.
//
// Optional build macro REGFILE_ARB_FAIRNESS_EN adds a starvation counter.
// Once B has been refused STARVE_LIMIT cycles in a row, B is forced through
// and A is held off for one cycle. Without the macro, A has strict priority
// and STARVE_LIMIT is ignored.

module regfile_wport_arb #(
    parameter int unsigned ADDR_SIZE    = 5,
    parameter int unsigned WORD_SIZE    = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 a_valid,
    output logic                 a_ready,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic [WORD_SIZE-1:0] a_data,

    input  logic                 b_valid,
    output logic                 b_ready,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic [WORD_SIZE-1:0] b_data,

    output logic                 d_we,
    output logic [ADDR_SIZE-1:0] d_addr,
    output logic [WORD_SIZE-1:0] d_data,

    input  logic [ADDR_SIZE-1:0] s_addr,
    input  logic [ADDR_SIZE-1:0] t_addr,
    output logic                 s_fwd,
    output logic                 t_fwd,
    output logic [WORD_SIZE-1:0] fwd_data
);

    logic                 force_b;
    logic                 grant_a;
    logic                 grant_b;

    logic                 d_we_d,   d_we_q;
    logic [ADDR_SIZE-1:0] d_addr_d, d_addr_q;
    logic [WORD_SIZE-1:0] d_data_d, d_data_q;

    // Arbitration. The ready signals never depend on the requester's own valid.
    always_comb begin
        a_ready = !force_b;
        b_ready = !a_valid || force_b;
        grant_a = a_valid && a_ready;
        // When B is not forced, b_ready is already low while A is requesting.
        // The !grant_a term makes exclusivity explicit.
        grant_b = b_valid && b_ready && !grant_a;
    end

    // Next state of the write port. A write to $zero uses the slot but does not
    // raise the write enable.
    always_comb begin
        d_we_d   = 1'b0;
        d_addr_d = d_addr_q;
        d_data_d = d_data_q;
        if (grant_a) begin
            d_we_d   = (a_addr != '0);
            d_addr_d = a_addr;
            d_data_d = a_data;
        end else if (grant_b) begin
            d_we_d   = (b_addr != '0);
            d_addr_d = b_addr;
            d_data_d = b_data;
        end
    end

    // Write-port register. Asserting reset drops any in-flight write at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_we_q   <= 1'b0;
            d_addr_q <= '0;
            d_data_q <= '0;
        end else begin
            d_we_q   <= d_we_d;
            d_addr_q <= d_addr_d;
            d_data_q <= d_data_d;
        end
    end

`ifdef REGFILE_ARB_FAIRNESS_EN
    localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

    logic [3:0] wait_cnt_d, wait_cnt_q;

    // Count the consecutive cycles in which B is refused. The count saturates
    // at the limit, and at the limit force_b raises b_ready.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!b_valid || grant_b) begin
            wait_cnt_d = '0;
        end else if (!b_ready && (wait_cnt_q != StarveLimit)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign force_b = (wait_cnt_q == StarveLimit);
`else
    logic [3:0] starve_limit_unused;

    assign starve_limit_unused = 4'(STARVE_LIMIT);
    assign force_b             = 1'b0;
`endif

    // Forward the write that is in flight. The register file commits it at the
    // end of this cycle, so a read in the same cycle would still see the old value.
    always_comb begin
        s_fwd    = d_we_q && (s_addr == d_addr_q) && (s_addr != '0);
        t_fwd    = d_we_q && (t_addr == d_addr_q) && (t_addr != '0);
        fwd_data = d_data_q;
    end

    assign d_we   = d_we_q;
    assign d_addr = d_addr_q;
    assign d_data = d_data_q;

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Testbench for regfile_wport_arb. Directed steps are followed by a randomized
// phase. A behavioural model tracks the arbitration outcome, the registered
// write and the writes that commit to each register.

module tb_regfile_wport_arb;

    localparam int unsigned ADDR_SIZE    = 5;
    localparam int unsigned WORD_SIZE    = 32;
    localparam int unsigned STARVE_LIMIT = 4;
`ifdef REGFILE_ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 a_valid, a_ready, b_valid, b_ready;
    logic [ADDR_SIZE-1:0] a_addr, b_addr, d_addr, s_addr, t_addr;
    logic [WORD_SIZE-1:0] a_data, b_data, d_data, fwd_data;
    logic                 d_we, s_fwd, t_fwd;

    always #5 clk = ~clk;

    regfile_wport_arb #(
        .ADDR_SIZE   (ADDR_SIZE),
        .WORD_SIZE   (WORD_SIZE),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .b_addr  (b_addr),
        .b_data  (b_data),
        .d_we    (d_we),
        .d_addr  (d_addr),
        .d_data  (d_data),
        .s_addr  (s_addr),
        .t_addr  (t_addr),
        .s_fwd   (s_fwd),
        .t_fwd   (t_fwd),
        .fwd_data(fwd_data)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: the pending registered write, and how many consecutive cycles B
    // has been refused.
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    int          m_streak;
    bit          ga, gb;

    // Per-register commit history, observed from the DUT and predicted by the model.
    int          dut_cnt[32];
    int          mdl_cnt[32];
    logic [31:0] dut_last[32];
    logic [31:0] mdl_last[32];

    int base3, base9;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check outputs at the falling edge against the model, then advance the
    // model across the next rising edge.
    task automatic cycle();
        bit   force_now;
        logic exp_ar, exp_br, exp_s, exp_t;
        @(negedge clk);
        force_now = FAIR && (m_streak >= int'(STARVE_LIMIT));
        exp_ar    = !force_now;
        exp_br    = !a_valid || force_now;
        exp_s     = m_we && (s_addr == m_addr) && (s_addr != 5'd0);
        exp_t     = m_we && (t_addr == m_addr) && (t_addr != 5'd0);
        check("a_ready", 32'(a_ready), 32'(exp_ar));
        check("b_ready", 32'(b_ready), 32'(exp_br));
        check("d_we", 32'(d_we), 32'(m_we));
        check("d_addr", 32'(d_addr), 32'(m_addr));
        check("d_data", d_data, m_data);
        check("fwd_data", fwd_data, m_data);
        check("s_fwd", 32'(s_fwd), 32'(exp_s));
        check("t_fwd", 32'(t_fwd), 32'(exp_t));
        if (d_we === 1'b1) begin
            dut_cnt[d_addr]++;
            dut_last[d_addr] = d_data;
        end
        if (m_we) begin
            mdl_cnt[m_addr]++;
            mdl_last[m_addr] = m_data;
        end
        ga = a_valid && !force_now;
        gb = b_valid && !ga && (force_now || !a_valid);
        if (ga) begin
            m_we = (a_addr != 5'd0); m_addr = a_addr; m_data = a_data;
        end else if (gb) begin
            m_we = (b_addr != 5'd0); m_addr = b_addr; m_data = b_data;
        end else begin
            m_we = 1'b0;
        end
        if (b_valid && !gb) m_streak++;
        else m_streak = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            dut_cnt[i] = 0; mdl_cnt[i] = 0; dut_last[i] = '0; mdl_last[i] = '0;
        end
        a_valid = 0; a_addr = '0; a_data = '0;
        b_valid = 0; b_addr = '0; b_data = '0;
        s_addr = '0; t_addr = '0;
        m_we = 0; m_addr = '0; m_data = '0; m_streak = 0; ga = 0; gb = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_d_we", 32'(d_we), 32'd0);
        check("rst_a_ready", 32'(a_ready), 32'd1);
        check("rst_b_ready", 32'(b_ready), 32'd1);
        check("rst_fwd_data", fwd_data, 32'd0);
        rst_n = 1'b1;

        // Idle
        cycle();
        cycle();

        // Single A write, then forwarding in the following cycle
        a_valid = 1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        cycle();
        a_valid = 0; s_addr = 5'd5; t_addr = 5'd6;
        #1;
        check("a5_d_we", 32'(d_we), 32'd1);
        check("a5_d_addr", 32'(d_addr), 32'd5);
        check("a5_d_data", d_data, 32'hDEADBEEF);
        check("a5_s_fwd", 32'(s_fwd), 32'd1);
        check("a5_t_fwd", 32'(t_fwd), 32'd0);
        check("a5_fwd_data", fwd_data, 32'hDEADBEEF);
        cycle();

        // B write to $zero takes the slot but does not raise the write enable
        b_valid = 1; b_addr = 5'd0; b_data = 32'h1234; s_addr = 5'd0; t_addr = 5'd0;
        #1;
        check("b0_b_ready", 32'(b_ready), 32'd1);
        cycle();
        b_valid = 0;
        #1;
        check("b0_d_we", 32'(d_we), 32'd0);
        check("b0_d_data", d_data, 32'h1234);
        check("b0_s_fwd", 32'(s_fwd), 32'd0);
        cycle();

        // Both requesters held continuously
        base3 = dut_cnt[3]; base9 = dut_cnt[9];
        a_valid = 1; a_addr = 5'd3; a_data = 32'hAAAA0003;
        b_valid = 1; b_addr = 5'd9; b_data = 32'hBBBB0009;
        if (FAIR) begin
            for (int i = 0; i < 10; i++) begin
                #1;
                check("fair_b_ready", 32'(b_ready), 32'((i % 5) == 4));
                check("fair_a_ready", 32'(a_ready), 32'((i % 5) != 4));
                cycle();
            end
        end else begin
            for (int i = 0; i < 20; i++) begin
                #1;
                check("strict_b_ready", 32'(b_ready), 32'd0);
                cycle();
            end
        end
        a_valid = 0; b_valid = 0;
        cycle();
        cycle();
        check("both_a_writes", 32'(dut_cnt[3] - base3), FAIR ? 32'd8 : 32'd20);
        check("both_b_writes", 32'(dut_cnt[9] - base9), FAIR ? 32'd2 : 32'd0);

        // Reset in the cycle after a B grant drops the write to r7
        b_valid = 1; b_addr = 5'd7; b_data = 32'h0000_0777; s_addr = 5'd7; t_addr = 5'd0;
        cycle();
        b_valid = 0;
        #1;
        check("r7_pre_d_we", 32'(d_we), 32'd1);
        check("r7_pre_d_addr", 32'(d_addr), 32'd7);
        check("r7_pre_s_fwd", 32'(s_fwd), 32'd1);
        rst_n = 1'b0;
        #1;
        check("r7_rst_d_we", 32'(d_we), 32'd0);
        check("r7_rst_d_addr", 32'(d_addr), 32'd0);
        check("r7_rst_d_data", d_data, 32'd0);
        check("r7_rst_s_fwd", 32'(s_fwd), 32'd0);
        rst_n = 1'b1;
        m_we = 0; m_addr = '0; m_data = '0; m_streak = 0;
        cycle();
        check("r7_no_write", 32'(dut_cnt[7]), 32'd0);

        // Random traffic. A requester holds its request until it is accepted.
        for (int n = 0; n < 400; n++) begin
            if (!a_valid || ga) begin
                a_valid = ($urandom_range(0, 3) != 0);
                a_addr  = 5'($urandom_range(0, 7));
                a_data  = $urandom;
            end
            if (!b_valid || gb) begin
                b_valid = ($urandom_range(0, 1) == 1);
                b_addr  = 5'($urandom_range(0, 7));
                b_data  = $urandom;
            end
            s_addr = 5'($urandom_range(0, 7));
            t_addr = 5'($urandom_range(0, 7));
            cycle();
        end
        a_valid = 0; b_valid = 0;
        cycle();
        cycle();

        for (int i = 0; i < 32; i++) begin
            check($sformatf("wr_cnt[%0d]", i), 32'(dut_cnt[i]), 32'(mdl_cnt[i]));
            check($sformatf("wr_last[%0d]", i), dut_last[i], mdl_last[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
